// File: rtl/ahb_bus_arbiter_if.sv
// Bundle of AHB arbitration signals shared by the masters, the slaves and the arbiter.
// The "master" modport is the bus side (drives requests, locks, split mask and HREADY).
// The "slave" modport is the arbiter side (drives grants, owner index and lock status).
interface ahb_bus_arbiter_if;
    logic [15:0] HBUSREQx;
    logic [15:0] HLOCKx;
    logic [15:0] HSPLIT;
    logic        HREADY;
    logic [15:0] HGRANTx;
    logic [3:0]  HMASTER;
    logic        HMASTLOCK;

    modport master (
        output HBUSREQx,
        output HLOCKx,
        output HSPLIT,
        output HREADY,
        input  HGRANTx,
        input  HMASTER,
        input  HMASTLOCK
    );

    modport slave (
        input  HBUSREQx,
        input  HLOCKx,
        input  HSPLIT,
        input  HREADY,
        output HGRANTx,
        output HMASTER,
        output HMASTLOCK
    );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// 16-master round-robin AHB arbiter: one-hot HGRANTx, owner index HMASTER, lock status HMASTLOCK.
// Latency: request seen while HREADY is low -> grant visible the next cycle; handover on next HREADY-high edge.
// Backpressure: grants are only issued while HREADY is low; a dropped request masks its grant immediately.
//
// Ports:
//   HCLK     - bus clock, all state on the rising edge
//   HRESETn  - synchronous active-low reset
//   bus      - arbitration bundle (requests, locks, split mask, HREADY in; grant, owner, lock status out)
module ahb_bus_arbiter (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_bus_arbiter_if.slave   bus
);

    logic [15:0] gnt_q;
    logic [3:0]  master_q;
    logic        mastlock_q;

    logic [15:0] elig;
    logic [15:0] sel;
    logic        sel_found;
    logic [3:0]  rr_idx;
    logic [15:0] grant_vis;
    logic [3:0]  grant_idx;

    // Eligible masters: requesting and not split. A locked owner that still
    // asserts its lock keeps the bus to itself.
    always_comb begin
        elig = bus.HBUSREQx & ~bus.HSPLIT;
        if (mastlock_q && bus.HLOCKx[master_q]) begin
            elig = elig & (16'h0001 << master_q);
        end
    end

    // Round-robin search starting just after the current owner. The 4-bit
    // index wraps naturally, so offset 16 lands back on the owner, which is
    // therefore considered last.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        rr_idx    = '0;
        for (int k = 1; k <= 16; k++) begin
            rr_idx = master_q + k[3:0];
            if (!sel_found && elig[rr_idx]) begin
                sel[rr_idx] = 1'b1;
                sel_found   = 1'b1;
            end
        end
    end

    // Grant register: cleared by every completed transfer, reloaded with the
    // arbitration result while the bus is stalled.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            gnt_q <= '0;
        end else if (bus.HREADY) begin
            gnt_q <= '0;
        end else begin
            gnt_q <= sel;
        end
    end

    // Masking with the live request removes a grant in the same cycle the
    // master withdraws, and guarantees no grant without a request.
    assign grant_vis = gnt_q & bus.HBUSREQx;

    // Index of the (at most one) visible grant bit.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (grant_vis[i]) begin
                grant_idx = i[3:0];
            end
        end
    end

    // Ownership handover on a completed transfer with a pending grant.
    // Without a handover the lock drops as soon as the owner releases HLOCKx.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            master_q   <= '0;
            mastlock_q <= 1'b0;
        end else if (bus.HREADY) begin
            if (grant_vis != 16'h0000) begin
                master_q   <= grant_idx;
                mastlock_q <= bus.HLOCKx[grant_idx];
            end else if (!bus.HLOCKx[master_q]) begin
                mastlock_q <= 1'b0;
            end
        end
    end

    assign bus.HGRANTx   = grant_vis;
    assign bus.HMASTER   = master_q;
    assign bus.HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed scenarios followed by random traffic.
// A reference model predicts outputs per cycle and pushes them to a queue; a monitor pops and compares.
// The monitor also checks one-hot0 grants and zero grants after every HREADY-high cycle.
module tb_ahb_bus_arbiter;

    logic HCLK;
    logic HRESETn;

    ahb_bus_arbiter_if bus ();

    ahb_bus_arbiter dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [15:0] gnt;
        logic [3:0]  master;
        logic        lock;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: current owner, lock flag, and the master holding
    // a pending grant (-1 when none).
    int m_owner  = 0;
    bit m_locked = 1'b0;
    int m_gnt    = -1;

    // Round-robin choice by the arbitration rules.
    function automatic int pick(int owner, bit locked, logic [15:0] req,
                                logic [15:0] lock, logic [15:0] split);
        logic [15:0] cand;
        int i;
        cand = req & ~split;
        for (int k = 1; k <= 16; k++) begin
            i = (owner + k) % 16;
            if (cand[i] && (!(locked && lock[owner]) || i == owner)) return i;
        end
        return -1;
    endfunction

    task automatic cycle(bit rstn, logic [15:0] req, logic [15:0] lock,
                         logic [15:0] split, bit ready);
        exp_t e;
        @(posedge HCLK);
        #1;
        HRESETn      = rstn;
        bus.HBUSREQx = req;
        bus.HLOCKx   = lock;
        bus.HSPLIT   = split;
        bus.HREADY   = ready;

        e.gnt    = (m_gnt >= 0 && req[m_gnt]) ? (16'h0001 << m_gnt) : 16'h0000;
        e.master = 4'(m_owner);
        e.lock   = m_locked;
        exp_q.push_back(e);

        if (!rstn) begin
            m_owner  = 0;
            m_locked = 1'b0;
            m_gnt    = -1;
        end else if (ready) begin
            if (e.gnt != 16'h0000) begin
                m_owner  = m_gnt;
                m_locked = lock[m_gnt];
            end else if (!lock[m_owner]) begin
                m_locked = 1'b0;
            end
            m_gnt = -1;
        end else begin
            m_gnt = pick(m_owner, m_locked, req, lock, split);
        end
    endtask

    // Monitor: compares observed outputs against the queued predictions.
    bit prev_ready = 1'b0;
    always @(negedge HCLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.HGRANTx !== e.gnt) begin
                failures++;
                $display("FAIL hgrant t=%0t got=%h exp=%h", $time, bus.HGRANTx, e.gnt);
            end
            checks++;
            if (bus.HMASTER !== e.master) begin
                failures++;
                $display("FAIL hmaster t=%0t got=%0d exp=%0d", $time, bus.HMASTER, e.master);
            end
            checks++;
            if (bus.HMASTLOCK !== e.lock) begin
                failures++;
                $display("FAIL hmastlock t=%0t got=%b exp=%b", $time, bus.HMASTLOCK, e.lock);
            end
            checks++;
            if ($countones(bus.HGRANTx) > 1) begin
                failures++;
                $display("FAIL onehot0 t=%0t got=%h exp=at most one bit", $time, bus.HGRANTx);
            end
            if (prev_ready) begin
                checks++;
                if (bus.HGRANTx !== 16'h0000) begin
                    failures++;
                    $display("FAIL grant_after_ready t=%0t got=%h exp=0000", $time, bus.HGRANTx);
                end
            end
            prev_ready = bus.HREADY;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] r, l, s;
        HRESETn      = 1'b0;
        bus.HBUSREQx = 16'hFFFF;
        bus.HLOCKx   = 16'h0000;
        bus.HSPLIT   = 16'h0000;
        bus.HREADY   = 1'b0;

        // Reset with all requests asserted
        cycle(0, 16'hFFFF, 16'h0000, 16'h0000, 0);
        cycle(0, 16'hFFFF, 16'h0000, 16'h0000, 0);
        // Single request from master 3, then handover
        cycle(1, 16'h0008, 16'h0000, 16'h0000, 0);
        cycle(1, 16'h0008, 16'h0000, 16'h0000, 1);
        cycle(1, 16'h0000, 16'h0000, 16'h0000, 0);
        // Round-robin from owner 3: master 0 first, then master 3
        cycle(1, 16'h0009, 16'h0000, 16'h0000, 0);
        cycle(1, 16'h0009, 16'h0000, 16'h0000, 1);
        cycle(1, 16'h0009, 16'h0000, 16'h0000, 0);
        cycle(1, 16'h0009, 16'h0000, 16'h0000, 1);
        cycle(1, 16'h0000, 16'h0000, 16'h0000, 0);
        // Request drop: grant to master 2 vanishes with its request
        cycle(1, 16'h0004, 16'h0000, 16'h0000, 0);
        cycle(1, 16'h0000, 16'h0000, 16'h0000, 0);
        cycle(1, 16'h0000, 16'h0000, 16'h0000, 1);
        // Lock: master 5 takes the bus locked, keeps it against master 0
        cycle(1, 16'h0020, 16'h0020, 16'h0000, 0);
        cycle(1, 16'h0020, 16'h0020, 16'h0000, 1);
        cycle(1, 16'h0021, 16'h0020, 16'h0000, 0);
        cycle(1, 16'h0021, 16'h0020, 16'h0000, 0);
        cycle(1, 16'h0021, 16'h0020, 16'h0000, 1);
        cycle(1, 16'h0021, 16'h0000, 16'h0000, 0);
        cycle(1, 16'h0021, 16'h0000, 16'h0000, 1);
        cycle(1, 16'h0000, 16'h0000, 16'h0000, 0);
        // Split: master 0 excluded
        cycle(1, 16'h0003, 16'h0000, 16'h0001, 0);
        cycle(1, 16'h0003, 16'h0000, 16'h0001, 0);
        cycle(1, 16'h0003, 16'h0000, 16'h0001, 1);
        // Boundary: owner 15 wraps to master 0 before master 14
        cycle(1, 16'h8000, 16'h0000, 16'h0000, 0);
        cycle(1, 16'h8000, 16'h0000, 16'h0000, 1);
        cycle(1, 16'hC001, 16'h0000, 16'h0000, 0);
        cycle(1, 16'hC001, 16'h0000, 16'h0000, 1);
        // Reset mid-arbitration
        cycle(1, 16'h0F0F, 16'h0000, 16'h0000, 0);
        cycle(0, 16'h0F0F, 16'h0000, 16'h0000, 0);
        cycle(1, 16'h0F0F, 16'h0000, 16'h0000, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r = 16'($urandom & $urandom);
            l = 16'($urandom & $urandom) | (($urandom_range(0, 3) != 0) ? (16'h0001 << m_owner) : 16'h0000);
            s = 16'($urandom & $urandom & $urandom);
            cycle(($urandom_range(0, 99) != 0), r, l, s, 1'($urandom_range(0, 1)));
        end

        @(posedge HCLK);
        @(negedge HCLK);
        @(posedge HCLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d exp=0 pending predictions", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
